// File: rtl/bit_stuffer_if.sv
// ---------------------------------------------------------------------------
// bit_stuffer_if
// Bundles the serial handshake between the CRC queue, the bit stuffer and
// the NRZI encoder.
//   s_in       : data bit at the CRC queue head
//   start_b    : packet-start strobe from the CRC block
//   endb       : queue-drained strobe from the CRC block (no data bit)
//   pause      : stall request back to the CRC queue
//   s_out      : serial bit towards NRZI
//   out_valid  : s_out carries a packet bit
//   start_nrzi : marks the first packet bit on s_out
//   end_nrzi   : pulses the cycle after the last packet bit
//   proto_err  : sticky protocol-violation flag
// master = upstream/downstream environment side, slave = bit stuffer side.
// ---------------------------------------------------------------------------
interface bit_stuffer_if;
  logic s_in;
  logic start_b;
  logic endb;
  logic pause;
  logic s_out;
  logic out_valid;
  logic start_nrzi;
  logic end_nrzi;
  logic proto_err;

  modport master (
    output s_in, start_b, endb,
    input  pause, s_out, out_valid, start_nrzi, end_nrzi, proto_err
  );

  modport slave (
    input  s_in, start_b, endb,
    output pause, s_out, out_valid, start_nrzi, end_nrzi, proto_err
  );
endinterface

// File: rtl/bit_stuffer.sv
// ---------------------------------------------------------------------------
// bit_stuffer
// Transmit-path stage between the CRC block and the NRZI encoder. Inserts a
// 0 after every MAX_ONES consecutive 1s, stalling the CRC queue with pause
// for the cycle in which the stuffed bit is emitted, and frames the output
// stream with start_nrzi / end_nrzi strobes.
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bit_stuffer_if.slave (s_in/start_b/endb in, pause, registered
//           s_out/out_valid/start_nrzi/end_nrzi, sticky proto_err out)
// Parameter:
//   MAX_ONES : run of 1s that triggers one stuffed 0 (2..15)
// ---------------------------------------------------------------------------
module bit_stuffer #(
  parameter int MAX_ONES = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  bit_stuffer_if.slave  bus
);

  localparam int CW = $clog2(MAX_ONES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ONES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2,
    ENDP  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   ones_cnt_reg;
  logic            end_pending_reg;
  logic            first_reg;
  logic            s_out_reg;
  logic            out_valid_reg;
  logic            start_nrzi_reg;
  logic            end_nrzi_reg;
  logic            proto_err_reg;

  logic [CW-1:0]   ones_inc;

  // Run count after accepting another 1; never exceeds MAX_ONES because the
  // count is cleared as soon as it reaches MAX_ONES.
  assign ones_inc = ones_cnt_reg + 1'b1;

  // The queue must hold its head bit while the stuffed 0 goes out.
  assign bus.pause      = (state_reg == STUFF);
  assign bus.s_out      = s_out_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.start_nrzi = start_nrzi_reg;
  assign bus.end_nrzi   = end_nrzi_reg;
  assign bus.proto_err  = proto_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ones_cnt_reg    <= '0;
      end_pending_reg <= 1'b0;
      first_reg       <= 1'b0;
      s_out_reg       <= 1'b0;
      out_valid_reg   <= 1'b0;
      start_nrzi_reg  <= 1'b0;
      end_nrzi_reg    <= 1'b0;
      proto_err_reg   <= 1'b0;
    end else begin
      // Output strobes are single-cycle unless a state below loads them.
      s_out_reg      <= 1'b0;
      out_valid_reg  <= 1'b0;
      start_nrzi_reg <= 1'b0;
      end_nrzi_reg   <= 1'b0;

      // A new packet can only begin from IDLE; anywhere else it is ignored.
      if (bus.start_b && (state_reg != IDLE)) begin
        proto_err_reg <= 1'b1;
      end

      unique case (state_reg)
        IDLE: begin
          // start_b has priority over a coincident endb.
          if (bus.start_b) begin
            state_reg    <= SEND;
            ones_cnt_reg <= '0;
            first_reg    <= 1'b1;
          end else if (bus.endb) begin
            proto_err_reg <= 1'b1;
          end
        end

        SEND: begin
          if (bus.endb) begin
            end_nrzi_reg <= 1'b1;
            first_reg    <= 1'b0;
            state_reg    <= IDLE;
          end else begin
            s_out_reg      <= bus.s_in;
            out_valid_reg  <= 1'b1;
            start_nrzi_reg <= first_reg;
            first_reg      <= 1'b0;
            if (bus.s_in) begin
              if (ones_inc == MAX_CNT) begin
                ones_cnt_reg <= '0;
                state_reg    <= STUFF;
              end else begin
                ones_cnt_reg <= ones_inc;
              end
            end else begin
              ones_cnt_reg <= '0;
            end
          end
        end

        STUFF: begin
          // s_in is ignored here; the queue is paused.
          s_out_reg     <= 1'b0;
          out_valid_reg <= 1'b1;
          if (end_pending_reg || bus.endb) begin
            // Remember the end so end_nrzi comes after the stuffed 0.
            end_pending_reg <= 1'b1;
            state_reg       <= ENDP;
          end else begin
            state_reg <= SEND;
          end
        end

        ENDP: begin
          end_nrzi_reg    <= 1'b1;
          end_pending_reg <= 1'b0;
          first_reg       <= 1'b0;
          state_reg       <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_stuffer.sv
// ---------------------------------------------------------------------------
// tb_bit_stuffer
// Drives packets into bit_stuffer the way the CRC queue would (hold the head
// bit while pause is high, pulse endb once drained) and checks every output
// cycle against an expected symbol stream produced by a run-length stuffing
// model. Covers directed cases, protocol errors, mid-packet reset and a
// randomized packet run.
// ---------------------------------------------------------------------------
module tb_bit_stuffer;

  localparam int MAX_ONES = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bit_stuffer_if bus ();

  bit_stuffer #(.MAX_ONES(MAX_ONES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // One expected output symbol: a packet bit or the end marker.
  typedef struct packed {
    logic       is_end;
    logic       b;
    logic       first;     // bit: first of packet; end: packet was empty
    logic [7:0] n_stuff;   // end only: number of stuffed zeros (pause cycles)
  } item_t;

  item_t exp_q[$];
  int    start_cyc = 0;
  logic  exp_perr = 1'b0;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Reference rule: emit each bit; after MAX_ONES consecutive 1s emit a 0
  // and restart the run.
  function automatic void stuff_model(input bit bits[$], output bit out[$],
                                      output int n_stuff);
    int run;
    run = 0;
    out = {};
    n_stuff = 0;
    foreach (bits[i]) begin
      out.push_back(bits[i]);
      if (bits[i]) begin
        run++;
        if (run == MAX_ONES) begin
          out.push_back(1'b0);
          n_stuff++;
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
  endfunction

  function automatic void vec_to_q(input logic [63:0] v, input int n, output bit q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(v[i]);
  endfunction

  function automatic logic [31:0] q_to_vec(input bit q[$]);
    logic [31:0] v;
    v = '0;
    foreach (q[i]) if (i < 32) v[i] = q[i];
    return v;
  endfunction

  task automatic do_reset(input bit chk);
    rst_n = 1'b0;
    bus.start_b = 1'b0;
    bus.endb = 1'b0;
    #1;
    if (chk)
      check("async_reset_outputs",
            {bus.pause, bus.s_out, bus.out_valid, bus.start_nrzi, bus.end_nrzi, bus.proto_err},
            0);
    exp_q.delete();
    exp_perr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Plays one packet as the CRC queue would. abort_after >= 0 resets the DUT
  // once that many bits are accepted; bad_start_at >= 0 injects a stray
  // start_b while that bit index is at the queue head.
  task automatic run_packet(input bit bits[$], input int abort_after,
                            input int bad_start_at, input bit start_with_endb);
    bit    out[$];
    int    ns;
    int    idx;
    int    bad_at;
    bit    consume;
    bit    bad;
    item_t it;

    stuff_model(bits, out, ns);
    foreach (out[i]) begin
      it.is_end = 1'b0;
      it.b = out[i];
      it.first = (i == 0);
      it.n_stuff = 8'd0;
      exp_q.push_back(it);
    end
    it.is_end = 1'b1;
    it.b = 1'b0;
    it.first = (bits.size() == 0);
    it.n_stuff = 8'(ns);
    exp_q.push_back(it);

    @(posedge clk); #1;
    bus.start_b = 1'b1;
    bus.endb = start_with_endb;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.start_b = 1'b0;
    bus.endb = 1'b0;

    idx = 0;
    bad_at = bad_start_at;
    forever begin
      if (abort_after >= 0 && idx == abort_after) begin
        do_reset(1'b1);
        return;
      end
      if (idx == bits.size()) begin
        bus.endb = 1'b1;
        bus.s_in = 1'($urandom);
        @(posedge clk); #1;
        bus.endb = 1'b0;
        break;
      end
      consume = !bus.pause;
      // While paused the head bit is not consumed; drive noise to show it
      // is ignored.
      bus.s_in = consume ? bits[idx] : 1'($urandom);
      bad = (idx == bad_at);
      bus.start_b = bad;
      @(posedge clk); #1;
      bus.start_b = 1'b0;
      if (bad) begin
        exp_perr = 1'b1;
        bad_at = -1;
      end
      if (consume) idx++;
    end

    for (int t = 0; t < 64 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Single compare process: every cycle out of reset.
  initial begin : compare_proc
    int    last_v;
    int    pcnt;
    item_t it;
    last_v = -10;
    pcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pcnt = 0;
        continue;
      end
      if (bus.pause) pcnt++;
      check("proto_err", bus.proto_err, exp_perr);
      if (bus.out_valid || bus.end_nrzi) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {bus.out_valid, bus.end_nrzi}, 0);
        end else begin
          it = exp_q.pop_front();
          if (!it.is_end) begin
            check("bit_kind", {bus.out_valid, bus.end_nrzi}, 2'b10);
            check("s_out", bus.s_out, it.b);
            check("start_nrzi", bus.start_nrzi, it.first);
            check("bit_timing", cyc, it.first ? start_cyc + 2 : last_v + 1);
            last_v = cyc;
          end else begin
            check("end_kind", {bus.out_valid, bus.end_nrzi}, 2'b01);
            check("start_nrzi_on_end", bus.start_nrzi, 0);
            check("end_timing", cyc, it.first ? start_cyc + 2 : last_v + 1);
            check("pause_cycles", pcnt, it.n_stuff);
            pcnt = 0;
          end
        end
      end else if (bus.start_nrzi) begin
        check("stray_start_nrzi", 1, 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          q[$];
    bit          mo[$];
    int          ns;
    logic [63:0] v;
    int          n;

    bus.s_in = 1'b0;
    bus.start_b = 1'b0;
    bus.endb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {bus.pause, bus.s_out, bus.out_valid, bus.start_nrzi, bus.end_nrzi, bus.proto_err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs",
          {bus.pause, bus.s_out, bus.out_valid, bus.start_nrzi, bus.end_nrzi, bus.proto_err}, 0);

    // Pin the model against hand-computed streams.
    vec_to_q(64'h01, 8, q);
    stuff_model(q, mo, ns);
    check("model_0x01_bits", q_to_vec(mo), 32'h01);
    check("model_0x01_len", mo.size(), 8);
    vec_to_q(64'hFFF, 12, q);
    stuff_model(q, mo, ns);
    check("model_12ones_bits", q_to_vec(mo), 32'h1FBF);
    check("model_12ones_len", mo.size(), 14);
    check("model_12ones_stuffs", ns, 2);
    vec_to_q(64'h7DF, 11, q);
    stuff_model(q, mo, ns);
    check("model_5_0_5_bits", q_to_vec(mo), 32'h7DF);
    check("model_5_0_5_len", mo.size(), 11);
    check("model_5_0_5_stuffs", ns, 0);

    // Directed packets.
    vec_to_q(64'h01, 8, q);   run_packet(q, -1, -1, 1'b0);
    vec_to_q(64'hFFF, 12, q); run_packet(q, -1, -1, 1'b0);
    vec_to_q(64'h7DF, 11, q); run_packet(q, -1, -1, 1'b0);
    vec_to_q(64'h7E, 7, q);   run_packet(q, -1, -1, 1'b0);  // endb lands in STUFF
    vec_to_q(64'h3F, 6, q);   run_packet(q, -1, -1, 1'b0);  // only bits are 1x6
    vec_to_q(64'h0, 0, q);    run_packet(q, -1, -1, 1'b0);  // empty packet
    vec_to_q(64'hA5, 8, q);   run_packet(q, -1, -1, 1'b1);  // start_b with endb

    // endb in IDLE, then stray start_b mid-packet; error stays sticky.
    @(posedge clk); #1;
    bus.endb = 1'b1;
    @(posedge clk); #1;
    bus.endb = 1'b0;
    exp_perr = 1'b1;
    vec_to_q(64'h0FF3, 14, q); run_packet(q, -1, 4, 1'b0);
    @(posedge clk); #1;
    do_reset(1'b0);

    // Reset after three accepted 1s, then 1x6 must stuff only after the 6th.
    vec_to_q(64'h3F, 6, q);   run_packet(q, 3, -1, 1'b0);
    vec_to_q(64'h3F, 6, q);   run_packet(q, -1, -1, 1'b0);

    // Randomized packets, biased towards long runs of 1s.
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(0, 40);
      v = '0;
      for (int i = 0; i < n; i++) v[i] = ($urandom_range(0, 9) < 8);
      vec_to_q(v, n, q);
      run_packet(q,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n)) : -1,
                 ($urandom_range(0, 7) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1,
                 1'($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_stuffer.md
Name: bit_stuffer

Overview:
- Transmit-path stage directly downstream of the CRC block; consumes its serial bit stream and start/end strobes.
- Inserts a 0 after every run of MAX_ONES consecutive 1s, as USB requires.
- Stalls the CRC queue with `pause` while the stuffed bit is emitted.
- Presents a registered, framed serial stream to the NRZI encoder.

Parameters:
- MAX_ONES, 6: run length of consecutive 1s that triggers insertion of one 0. Legal range 2..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_in  input  1  data bit from the CRC queue head; valid every cycle in SEND with pause=0 and endb=0.
- start_b  input  1  one-cycle pulse from CRC; packet begins, first data bit on the following cycle.
- endb  input  1  one-cycle pulse from CRC; queue drained, carries no data bit.
- pause  output  1  combinational; 1 only in state STUFF; upstream must not advance its queue while high.
- s_out  output  1  registered serial bit to NRZI.
- out_valid  output  1  registered; s_out carries a packet bit this cycle.
- start_nrzi  output  1  registered pulse coincident with the first out_valid of a packet.
- end_nrzi  output  1  registered pulse in the cycle after the last out_valid of a packet.
- proto_err  output  1  sticky; set on protocol violation, cleared only by reset.

Behaviour:
- Reset values: all outputs 0, state IDLE, ones_cnt=0, end_pending=0, first flag=0.
- ones_cnt width is clog2(MAX_ONES+1).
- A bit is *accepted* in cycle k when state=SEND, endb=0.
- An accepted bit appears on s_out with out_valid=1 in cycle k+1 (latency 1).
- IDLE:
  - start_b=1 -> SEND; clear ones_cnt; set first flag.
  - endb=1 -> set proto_err, stay IDLE.
  - start_b and endb both 1 -> start wins, endb ignored, no error.
- SEND:
  - endb=1 -> end_nrzi=1 next cycle, out_valid=0 next cycle, -> IDLE.
  - Accepted bit 1 -> ones_cnt+1; if the new count equals MAX_ONES -> STUFF, ones_cnt cleared.
  - Accepted bit 0 -> ones_cnt cleared.
  - The first accepted bit after start_b drives start_nrzi=1 with it; the first flag then clears.
- STUFF (exactly one cycle):
  - pause=1; s_in ignored; register loads s_out=0, out_valid=1.
  - endb=1 this cycle sets end_pending.
  - Next state is ENDP if end_pending or endb, else SEND.
- ENDP: out_valid=0 next cycle, end_nrzi=1 next cycle, clear end_pending, -> IDLE.
- start_b in any state other than IDLE: ignored, proto_err set.
- The stuffed 0 is always emitted, even when the sixth 1 is the final packet bit. end_nrzi follows the stuffed 0, never precedes it.
- After a stuffed 0, the run count restarts at 0. The stuffed bit does not itself count.
- Back-to-back packets: start_b may arrive in the same cycle the FSM returns to IDLE's next-state decision only once IDLE is reached. A start_b one cycle after end_nrzi is accepted normally.
- Reset asserted mid-packet: immediate return to reset values. No end_nrzi is generated.
- Empty packet (endb immediately after start_b) yields no out_valid and no start_nrzi; end_nrzi pulses once.

Test Plan:
- Packet 0x01 LSB-first after start_b: s_out = 1,0,0,0,0,0,0,0 over 8 valid cycles; start_nrzi on first; no pause; end_nrzi one cycle after 8th bit.
- Twelve consecutive 1s: output 1×6, 0, 1×6, 0 (14 valid cycles); pause high in exactly 2 cycles, each one cycle after the 6th and 12th accepted 1; s_in held during pause not consumed.
- Pattern 1×5, 0, 1×5: no stuffing, 11 valid bits, pause never asserted.
- Last bit is the 6th consecutive 1 and endb arrives during STUFF: stuffed 0 emitted, then end_nrzi next cycle; proto_err stays 0.
- rst_n pulled low after 3 accepted 1s: all outputs 0 asynchronously. A new packet of 1×6 afterward stuffs after the 6th 1, not the 3rd, so the count restarted.
- endb in IDLE, and start_b during SEND: proto_err=1 and stays 1 until reset; packet in flight unaffected.
